shift_register: RTL and testbench

//   Serial-in, parallel-out (SIPO) shift register.
//   One serial bit enters on every rising clock edge. The full register contents are

---
 rtl/shift_register.sv | 42 ++++
 tb/tb_shift_register.sv | 124 ++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// shift_register
//   Serial-in, parallel-out shift register. One bit enters at the LSB on every
//   rising clock edge. The oldest bit falls off the MSB end. There is no enable,
//   so the register shifts on every cycle while out of reset. It serves as a
//   bit-stream deserialiser or as a history/delay line.
//
// Parameters
//   WIDTH      number of stages and width of sr_o (must be >= 2)
//   RESET_VAL  value forced into the register while reset is high
//
// Ports
//   clk    in   1      clock; the register updates on the rising edge
//   reset  in   1      asynchronous, active-high; clears the register immediately
//   x_i    in   1      serial data in
//   sr_o   out  WIDTH  register contents; [0] = newest bit, [WIDTH-1] = oldest bit
module shift_register #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_i,
    output logic [WIDTH-1:0] sr_o
);

    logic [WIDTH-1:0] sr_q;

    // Reset is in the sensitivity list, so it clears all stages without
    // waiting for a clock edge. It also wins over any edge that arrives
    // while it is held. An unknown x_i is shifted in as-is; it is not masked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sr_q <= RESET_VAL;
        else
            sr_q <= {sr_q[WIDTH-2:0], x_i};
    end

    // The output is taken straight from the flops, so there is no
    // combinational path from x_i to sr_o.
    assign sr_o = sr_q;

endmodule

// File: tb/tb_shift_register.sv
// tb_shift_register
//   Directed-vector bench for shift_register. It uses three instances:
//     u4    WIDTH=4 with the default reset value
//     u8    WIDTH=8 with the default reset value
//     u8f   WIDTH=8 with RESET_VAL=8'hFF
//   All three share the clock, reset and serial input. Inputs change 1 time
//   unit after a rising edge, and outputs are sampled at that same point.
module tb_shift_register;

    logic       clk;
    logic       reset;
    logic       x;
    logic [3:0] sr4;
    logic [7:0] sr8;
    logic [7:0] sr8f;

    int errors = 0;
    int checks = 0;

    shift_register #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .x_i(x), .sr_o(sr4)
    );

    shift_register #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .x_i(x), .sr_o(sr8)
    );

    shift_register #(.WIDTH(8), .RESET_VAL(8'hFF)) u8f (
        .clk(clk), .reset(reset), .x_i(x), .sr_o(sr8f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value, counts the
    // check, and prints a FAIL line on a mismatch.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    // Drives one serial bit, waits for the edge that samples it, then
    // moves just past that edge.
    task automatic step(input logic b);
        x = b;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp4 [4];
    logic [7:0] pat;

    initial begin
        reset = 1'b1;
        x     = 1'b0;

        // Hold reset for 2 cycles with x low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w4",   {4'h0, sr4}, 8'h00);
        chk("rst_w8",   sr8,         8'h00);
        chk("rst_w8ff", sr8f,        8'hFF);

        // Basic shift after release: x = 1,0,1,1.
        reset = 1'b0;
        exp4 = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        step(1'b1); chk("shift0", {4'h0, sr4}, {4'h0, exp4[0]});
        step(1'b0); chk("shift1", {4'h0, sr4}, {4'h0, exp4[1]});
        step(1'b1); chk("shift2", {4'h0, sr4}, {4'h0, exp4[2]});
        step(1'b1); chk("shift3", {4'h0, sr4}, {4'h0, exp4[3]});

        // Flush with two zeros.
        step(1'b0); chk("flush0", {4'h0, sr4}, 8'b0000_0110);
        step(1'b0); chk("flush1", {4'h0, sr4}, 8'b0000_1100);

        // Fill with ones starting from 1100, then drain with zeros.
        step(1'b1); chk("fill0",  {4'h0, sr4}, 8'b0000_1001);
        step(1'b1); chk("fill1",  {4'h0, sr4}, 8'b0000_0011);
        step(1'b1); chk("fill2",  {4'h0, sr4}, 8'b0000_0111);
        step(1'b1); chk("fill3",  {4'h0, sr4}, 8'b0000_1111);
        step(1'b0); chk("drain0", {4'h0, sr4}, 8'b0000_1110);
        step(1'b0); chk("drain1", {4'h0, sr4}, 8'b0000_1100);
        step(1'b0); chk("drain2", {4'h0, sr4}, 8'b0000_1000);
        step(1'b0); chk("drain3", {4'h0, sr4}, 8'b0000_0000);

        // Reset mid-operation: load 1011, then pulse reset between edges.
        step(1'b1); step(1'b0); step(1'b1); step(1'b1);
        chk("pre_pulse", {4'h0, sr4}, 8'b0000_1011);
        #2 reset = 1'b1;
        #1;
        chk("pulse_w4",   {4'h0, sr4}, 8'h00);
        chk("pulse_w8ff", sr8f,        8'hFF);
        reset = 1'b0;
        step(1'b1);
        chk("post_pulse", {4'h0, sr4}, 8'b0000_0001);
        chk("post_pulse_w8ff", sr8f,  8'hFF);

        // WIDTH=8 sweep: reset again, then shift in 8'hA5 MSB first.
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_w8ff", sr8f, 8'hFF);
        reset = 1'b0;
        pat = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            step(pat[i]);
            if (i == 4) chk("half_w8ff", sr8f, 8'hFA);
        end
        chk("a5_w8",   sr8,         8'hA5);
        chk("a5_w8ff", sr8f,        8'hA5);
        chk("a5_w4",   {4'h0, sr4}, 8'h05);

        // The oldest bit leaves on the next edge.
        step(1'b0);
        chk("a5_out_w8", sr8, 8'h4A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
